// File: rtl/fsm_seq_sched_if.sv
// fsm_seq_sched_if: requester/core bundle for the round-robin sequence-core scheduler.
// Ports (slave = scheduler view):
//   req, frame_data, core_out                       -> into the scheduler
//   gnt, core_in, core_rst_n, done, done_id, result, frame_cnt -> out of the scheduler
// The master modport is the view of the requesters plus the shared core.
interface fsm_seq_sched_if #(
    parameter int NREQ    = 4,
    parameter int FRAME_W = 8,
    parameter int ID_W    = 2
);
    logic [NREQ-1:0]         req;
    logic [NREQ*FRAME_W-1:0] frame_data;
    logic [NREQ-1:0]         gnt;
    logic                    core_in;
    logic                    core_rst_n;
    logic [1:0]              core_out;
    logic                    done;
    logic [ID_W-1:0]         done_id;
    logic [2*FRAME_W-1:0]    result;
    logic [7:0]              frame_cnt;

    modport master (
        output req, frame_data, core_out,
        input  gnt, core_in, core_rst_n, done, done_id, result, frame_cnt
    );

    modport slave (
        input  req, frame_data, core_out,
        output gnt, core_in, core_rst_n, done, done_id, result, frame_cnt
    );
endinterface

// File: rtl/fsm_seq_sched.sv
// fsm_seq_sched: round-robin scheduler serialising requester frames through one shared 4-state sequence core.
// Ports: clk (rising edge), rst (async, active-low), bus (fsm_seq_sched_if.slave):
//   req/frame_data from requesters, gnt one-hot grant, core_in/core_rst_n/core_out to the core,
//   done pulse with done_id and packed result, frame_cnt completed frames.
// Optional: define FSM_SCHED_COUNT_EN to enable the frame_cnt counter (tied to 0 otherwise).
module fsm_seq_sched #(
    parameter int NREQ    = 4,
    parameter int FRAME_W = 8,
    parameter int ID_W    = 2
) (
    input logic            clk,
    input logic            rst,
    fsm_seq_sched_if.slave bus
);
    localparam int CW = $clog2(FRAME_W);

    typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;

    state_t               state, state_nx;
    logic [ID_W-1:0]      ptr, pick, id_q;
    logic                 found;
    logic [NREQ-1:0]      gnt_nx, gnt_q;
    logic [FRAME_W-1:0]   frame_sel, sh;
    logic [CW-1:0]        bit_cnt;
    logic [2*FRAME_W-1:0] res_q;

    // First pass searches from ptr upward, second pass wraps to index 0.
    always_comb begin
        found     = 1'b0;
        pick      = '0;
        gnt_nx    = '0;
        frame_sel = '0;
        for (int j = 0; j < NREQ; j++)
            if (!found && j >= int'(ptr) && bus.req[j]) begin
                found     = 1'b1;
                pick      = ID_W'(j);
                gnt_nx[j] = 1'b1;
                frame_sel = bus.frame_data[j*FRAME_W +: FRAME_W];
            end
        for (int j = 0; j < NREQ; j++)
            if (!found && bus.req[j]) begin
                found     = 1'b1;
                pick      = ID_W'(j);
                gnt_nx[j] = 1'b1;
                frame_sel = bus.frame_data[j*FRAME_W +: FRAME_W];
            end
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_nx;

    always_comb begin
        state_nx       = state;
        bus.core_in    = 1'b0;
        bus.done       = 1'b0;
        bus.core_rst_n = rst & (state != CLR);
        case (state)
            IDLE:    state_nx = found ? CLR : IDLE;
            CLR:     state_nx = SHIFT;
            SHIFT: begin
                bus.core_in = sh[0];
                state_nx    = (bit_cnt == CW'(FRAME_W-1)) ? DRAIN : SHIFT;
            end
            DRAIN:   state_nx = DONE;
            DONE: begin
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The core output for bit k appears one cycle late, so slot k-1 is captured
    // at the end of SHIFT cycle k and the final slot during DRAIN.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            ptr     <= '0;
            gnt_q   <= '0;
            id_q    <= '0;
            sh      <= '0;
            bit_cnt <= '0;
            res_q   <= '0;
        end else
            case (state)
                IDLE:
                    if (found) begin
                        gnt_q   <= gnt_nx;
                        id_q    <= pick;
                        sh      <= frame_sel;
                        bit_cnt <= '0;
                        res_q   <= '0;
                    end
                SHIFT: begin
                    sh      <= sh >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    for (int k = 1; k < FRAME_W; k++)
                        if (bit_cnt == CW'(k)) res_q[2*(k-1) +: 2] <= bus.core_out;
                end
                DRAIN:   res_q[2*(FRAME_W-1) +: 2] <= bus.core_out;
                DONE: begin
                    gnt_q <= '0;
                    ptr   <= (int'(id_q) == NREQ-1) ? '0 : id_q + 1'b1;
                end
                default: ;
            endcase

    assign bus.gnt     = gnt_q;
    assign bus.done_id = id_q;
    assign bus.result  = res_q;

`ifdef FSM_SCHED_COUNT_EN
    logic [7:0] cnt_q;

    always_ff @(posedge clk or negedge rst)
        if (!rst)               cnt_q <= '0;
        else if (state == DONE) cnt_q <= cnt_q + 8'd1;

    assign bus.frame_cnt = cnt_q;
`else
    assign bus.frame_cnt = '0;
`endif
endmodule

// File: tb/tb_fsm_seq_sched.sv
// tb_fsm_seq_sched: directed bench for fsm_seq_sched with a behavioural 4-state sequence core.
// Core: on in=1 it emits 1,2,0 cyclically (state advances); on in=0 it emits 0 and holds state.
module tb_fsm_seq_sched;
    localparam int NREQ = 4;
    localparam int FW   = 8;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic in_or = 1'b0;
    logic [1:0] cs;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fsm_seq_sched_if #(.NREQ(NREQ), .FRAME_W(FW), .ID_W(IDW)) bus ();

    fsm_seq_sched #(.NREQ(NREQ), .FRAME_W(FW), .ID_W(IDW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always_ff @(posedge clk or negedge bus.core_rst_n)
        if (!bus.core_rst_n) begin
            cs           <= 2'd0;
            bus.core_out <= 2'd0;
        end else begin
            bus.core_out <= !bus.core_in ? 2'd0 : (cs == 2'd2 ? 2'd0 : cs + 2'd1);
            if (bus.core_in) cs <= (cs == 2'd2) ? 2'd0 : cs + 2'd1;
        end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        in_or |= bus.core_in;
    endtask

    task automatic wait_gnt();
        int n = 0;
        do begin
            tick();
            n++;
        end while (bus.gnt == '0 && n < 20);
        if (bus.gnt == '0) check("gnt_timeout", 0, 1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.done && n < 40);
        if (!bus.done) check("done_timeout", 0, 1);
    endtask

    task automatic serve(input string tag, input int exp_id, input logic [15:0] exp_res);
        int n;
        wait_gnt();
        check({tag, "_gnt"}, 32'(bus.gnt), 32'(1) << exp_id);
        wait_done(n);
        check({tag, "_lat"}, n, 10);
        check({tag, "_id"}, 32'(bus.done_id), exp_id);
        check({tag, "_res"}, 32'(bus.result), 32'(exp_res));
    endtask

    initial begin
        int n, last;
        int ids[5] = '{0, 1, 2, 3, 0};
        logic [15:0] rs[5] = '{16'h9249, 16'h0001, 16'h0000, 16'h4084, 16'h9249};
        bus.req = '0;
        bus.frame_data = '0;
        tick();
        check("rst_gnt", 32'(bus.gnt), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_id", 32'(bus.done_id), 0);
        check("rst_res", 32'(bus.result), 0);
        check("rst_cnt", 32'(bus.frame_cnt), 0);
        check("rst_core", 32'(bus.core_rst_n), 0);
        check("rst_in", 32'(bus.core_in), 0);
        rst = 1'b1;

        bus.frame_data[7:0] = 8'hFF;
        bus.req = 4'b0001;
        serve("single", 0, 16'h9249);
        bus.req = '0;
        tick();
        check("pulse_done", 32'(bus.done), 0);
        check("pulse_gnt", 32'(bus.gnt), 0);
        check("hold_res", 32'(bus.result), 32'h9249);
        check("hold_id", 32'(bus.done_id), 0);

        in_or = 1'b0;
        bus.frame_data[23:16] = 8'h00;
        bus.req = 4'b0100;
        serve("zero", 2, 16'h0000);
        check("zero_in", 32'(in_or), 0);
        bus.req = '0;

        bus.frame_data[7:0] = 8'h01;
        bus.req = 4'b0001;
        serve("clr_a", 0, 16'h0001);
        bus.frame_data[7:0] = 8'hFF;
        serve("clr_b", 0, 16'h9249);
        bus.req = '0;

        bus.frame_data[15:8] = 8'hFF;
        bus.req = 4'b0010;
        wait_gnt();
        check("mid_gnt", 32'(bus.gnt), 32'h2);
        repeat (4) tick();
        bus.req = '0;
        bus.frame_data[15:8] = 8'h00;
        wait_done(n);
        check("mid_lat", n, 6);
        check("mid_id", 32'(bus.done_id), 1);
        check("mid_res", 32'(bus.result), 32'h9249);

        #2 rst = 1'b0;
        tick();
        rst = 1'b1;
        bus.frame_data = {8'hAA, 8'h00, 8'h01, 8'hFF};
        bus.req = 4'b1111;
        last = 0;
        for (int i = 0; i < 5; i++) begin
            serve($sformatf("rr%0d", i), ids[i], rs[i]);
            if (i > 0) check($sformatf("rr%0d_period", i), cyc - last, 12);
            last = cyc;
        end

        bus.req = 4'b1000;
        bus.frame_data[31:24] = 8'hFF;
        wait_gnt();
        check("abort_gnt", 32'(bus.gnt), 32'h8);
        repeat (3) tick();
        #2 rst = 1'b0;
        #1;
        check("abort_gnt0", 32'(bus.gnt), 0);
        check("abort_done", 32'(bus.done), 0);
        check("abort_core", 32'(bus.core_rst_n), 0);
        bus.req = 4'b1001;
        tick();
        tick();
        check("abort_nodone", 32'(bus.done), 0);
        rst = 1'b1;
        serve("post_rst", 0, 16'h9249);

        #2 rst = 1'b0;
        tick();
        rst = 1'b1;
        check("cnt_zero", 32'(bus.frame_cnt), 0);
        bus.req = 4'b0001;
        for (int i = 0; i < 257; i++) wait_done(n);
        bus.req = '0;
        tick();
`ifdef FSM_SCHED_COUNT_EN
        check("cnt_wrap", 32'(bus.frame_cnt), 1);
`else
        check("cnt_off", 32'(bus.frame_cnt), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fsm_seq_sched.md
Name: fsm_seq_sched

Overview:
- Round-robin scheduler that shares one 4-state Mealy sequence core (1-bit `in`, 2-bit `out`, async active-low reset) among NREQ requesters.
- Each requester submits a FRAME_W-bit frame. The scheduler grants one requester, clears the core, and shifts the frame into the core serially, LSB first.
- It collects the 2-bit core output for every bit and returns the packed result with a done pulse tagged by requester id.
- Sits between the requester blocks and the single shared core instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- FRAME_W, 8, bits per frame (2..32).
- ID_W, 2, width of requester id; must be ≥ clog2(NREQ).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester request level.
- frame_data  input  NREQ*FRAME_W  frame of requester i at [i*FRAME_W +: FRAME_W].
- gnt  output  NREQ  one-hot grant; held for the whole service.
- core_in  output  1  serial bit to the core's `in`.
- core_rst_n  output  1  to the core reset; low clears the core to its initial state.
- core_out  input  2  core `out`.
- done  output  1  one-cycle pulse; result valid.
- done_id  output  ID_W  index of the requester served.
- result  output  2*FRAME_W  core output for bit k at [2k+1:2k].
- frame_cnt  output  8  frames completed (see Optional Feature).

Behaviour:
- Reset (rst=0, async): state=IDLE, rr pointer=0, gnt=0, core_in=0, done=0, done_id=0, result=0, frame_cnt=0, bit counter=0.
- core_rst_n = rst AND (state != CLR).
- IDLE:
  - If req != 0, grant the first set req bit searching from the rr pointer upward with wrap.
  - On that edge: register gnt and done_id, latch that requester's frame into an internal shift register, go to CLR.
  - If req = 0, stay in IDLE.
- CLR, 1 cycle: core_rst_n=0, core_in=0, go to SHIFT.
- SHIFT, FRAME_W cycles:
  - In cycle k, core_in = frame bit k.
  - The core updates at the end of cycle k; its out for bit k is valid during cycle k+1.
  - At the end of each SHIFT cycle k ≥ 1, capture core_out into result[2(k-1)+1:2(k-1)].
  - After cycle FRAME_W-1, go to DRAIN.
- DRAIN, 1 cycle: core_in=0; capture core_out into the slot for bit FRAME_W-1; go to DONE.
- DONE, 1 cycle:
  - done=1; result and done_id valid.
  - rr pointer = granted index + 1, mod NREQ.
  - gnt drops on exit; go to IDLE.
- Latency: done is high in the cycle following edge FRAME_W+2, counting the grant edge as edge 0. Throughput is one frame per FRAME_W+4 cycles.
- result and done_id hold their values until the next service's captures overwrite them. result is cleared to 0 on the grant edge.
- Frame data is latched at grant. Later changes to frame_data or deassertion of req are ignored until DONE.
- A requester still asserting req in DONE is eligible again, but only after the others in round-robin order.
- req bits at index ≥ NREQ do not exist; gnt is never more than one-hot.
- Async reset mid-service aborts immediately:
  - core_rst_n goes low with rst.
  - No done pulse is produced.
  - The rr pointer returns to 0.

Optional Feature:
- Macro: FSM_SCHED_COUNT_EN.
- Defined: frame_cnt increments by 1 on every DONE cycle, wraps 255→0, and resets to 0 on rst.
- Undefined: no counter logic; frame_cnt is tied to 0. The port list is unchanged.

Test Plan:
- Single frame: NREQ=4, FRAME_W=8, req=4'b0001, frame=8'hFF → gnt=0001. done fires 10 edges after grant with done_id=0 and result=16'h9249 (outputs 1,2,0,1,2,0,1,2).
- Zero frame: req=4'b0100, frame=8'h00 → done_id=2, result=16'h0000, core_in=0 throughout SHIFT.
- Round robin: req=4'b1111 held → done_id sequence 0,1,2,3,0. Each service lasts 12 cycles, and the next grant is 1 cycle after DONE.
- Core clear between frames: a frame that leaves the core in a nonzero state, followed by frame 8'hFF → result=16'h9249 again, showing core_rst_n was pulsed low for exactly one cycle in CLR.
- Mid-service changes: req drops and frame_data changes during SHIFT → the original frame's result completes unchanged. Async rst low during SHIFT → gnt=0 and done=0 immediately, and after release the first grant searches from index 0.
- With FSM_SCHED_COUNT_EN defined: 257 frames → frame_cnt=1. Without the macro, frame_cnt stays 0.
